// File: rtl/clock_generator_if.sv
// rtl/clock_generator_if.sv - control and status bundle of the processor clock generator
// Ports (master = controller side, slave = clock generator side):
//   run         master->slave  1 = free-run, 0 = halt
//   step        master->slave  single-step request, rising edge significant
//   proc_clk    slave->master  generated processor clock
//   tick        slave->master  one reference cycle pulse on each proc_clk rise
//   cycle_count slave->master  proc_clk rising edges since reset, wrapping
interface clock_generator_if #(
   parameter int COUNT_W = 32
);
   logic               run;
   logic               step;
   logic               proc_clk;
   logic               tick;
   logic [COUNT_W-1:0] cycle_count;

   modport master (
      output run,
      output step,
      input  proc_clk,
      input  tick,
      input  cycle_count
   );

   modport slave (
      input  run,
      input  step,
      output proc_clk,
      output tick,
      output cycle_count
   );
endinterface

// File: rtl/clock_generator.sv
// rtl/clock_generator.sv - even-ratio 50% duty processor clock with free-run and single-step
// Ports:
//   clk  reference clock, all state updates on its rising edge
//   rst  asynchronous active-high reset
//   bus  clock_generator_if.slave: run/step in, proc_clk/tick/cycle_count out
// Parameters:
//   DIV      even division ratio >= 2, proc_clk period = DIV reference cycles
//   COUNT_W  width of cycle_count
module clock_generator #(
   parameter int DIV     = 2,
   parameter int COUNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   clock_generator_if.slave  bus
);
   typedef enum logic [1:0] {
      S_HALT = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2
   } state_t;

   localparam int HALF  = DIV / 2;
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               clk_q;
   logic               tick_q;
   logic [COUNT_W-1:0] count_q;
   logic               step_d;
   logic               stepped;   // the single-step period has already produced its falling edge

   logic cnt_last;
   logic step_edge;
   logic engine_on;

   assign cnt_last  = (cnt == CNT_LAST);
   assign step_edge = bus.step & ~step_d;

   // The half-period engine advances whenever the clock must keep moving:
   //   HALT: only when run asks for it, so a restart begins counting on the same edge
   //   RUN:  while running, or to finish a high phase after run drops
   //   STEP: until the low phase following the single high phase is complete
   always_comb begin
      engine_on = 1'b0;
      case (state)
         S_HALT:  engine_on = bus.run;
         S_RUN:   engine_on = bus.run | clk_q;
         S_STEP:  engine_on = bus.run | clk_q | ~stepped | ~cnt_last;
         default: engine_on = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_HALT;
         cnt     <= '0;
         clk_q   <= 1'b0;
         tick_q  <= 1'b0;
         count_q <= '0;
         step_d  <= 1'b0;
         stepped <= 1'b0;
      end else begin
         step_d <= bus.step;
         tick_q <= 1'b0;

         if (engine_on) begin
            if (cnt_last) begin
               cnt   <= '0;
               clk_q <= ~clk_q;
               if (!clk_q) begin
                  count_q <= count_q + 1'b1;
                  tick_q  <= 1'b1;
               end
            end else begin
               cnt <= cnt + 1'b1;
            end
         end

         // State transitions; assignments here override the engine where they overlap.
         case (state)
            S_HALT: begin
               if (bus.run) begin
                  state <= S_RUN;
               end else begin
                  cnt   <= '0;
                  clk_q <= 1'b0;
                  if (step_edge) begin
                     state   <= S_STEP;
                     stepped <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (!bus.run) begin
                  if (!clk_q) begin
                     // Low phase only gets longer by halting here, never shorter.
                     state <= S_HALT;
                     cnt   <= '0;
                  end else if (cnt_last) begin
                     state <= S_HALT;
                  end
               end
            end
            S_STEP: begin
               if (bus.run) begin
                  state <= S_RUN;
               end else if (!engine_on) begin
                  state <= S_HALT;
                  cnt   <= '0;
               end else if (clk_q && cnt_last) begin
                  stepped <= 1'b1;
               end
            end
            default: begin
               state <= S_HALT;
               cnt   <= '0;
               clk_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.proc_clk    = clk_q;
   assign bus.tick        = tick_q;
   assign bus.cycle_count = count_q;
endmodule

// File: tb/tb_clock_generator.sv
// tb/tb_clock_generator.sv - directed self-checking bench for clock_generator
module tb_clock_generator;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   clock_generator_if #(.COUNT_W(32)) if2 ();
   clock_generator_if #(.COUNT_W(32)) if4 ();
   clock_generator_if #(.COUNT_W(3))  if3 ();

   clock_generator #(.DIV(2), .COUNT_W(32)) u_div2 (.clk(clk), .rst(rst), .bus(if2));
   clock_generator #(.DIV(4), .COUNT_W(32)) u_div4 (.clk(clk), .rst(rst), .bus(if4));
   clock_generator #(.DIV(2), .COUNT_W(3))  u_wrap (.clk(clk), .rst(rst), .bus(if3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      bit [0:9] step_v;
      bit [0:9] clk_v;
      bit [0:9] tick_v;
      bit [0:9] inc_v;

      checks = 0;
      errors = 0;
      rst      = 1'b1;
      if2.run  = 1'b1;  if2.step = 1'b0;
      if4.run  = 1'b1;  if4.step = 1'b0;
      if3.run  = 1'b1;  if3.step = 1'b0;

      // Held in reset across several reference edges
      repeat (3) @(negedge clk);
      check("rst_clk2",   {31'd0, if2.proc_clk}, 32'd0);
      check("rst_tick2",  {31'd0, if2.tick},     32'd0);
      check("rst_count2", if2.cycle_count,       32'd0);
      check("rst_clk4",   {31'd0, if4.proc_clk}, 32'd0);
      check("rst_count3", {29'd0, if3.cycle_count}, 32'd0);

      // Release at a falling edge; edge n = n-th rising edge after release
      rst = 1'b0;
      for (int n = 1; n <= 18; n++) begin
         @(negedge clk);
         // DIV=2: rises on edge 1, toggles every edge
         check($sformatf("run2_clk_e%0d", n),   {31'd0, if2.proc_clk}, 32'(n % 2));
         check($sformatf("run2_tick_e%0d", n),  {31'd0, if2.tick},     32'(n % 2));
         check($sformatf("run2_count_e%0d", n), if2.cycle_count,       32'((n + 1) / 2));
         // DIV=4: rises on edge 2, high 2 / low 2
         check($sformatf("run4_clk_e%0d", n),   {31'd0, if4.proc_clk}, 32'((n / 2) % 2));
         check($sformatf("run4_tick_e%0d", n),  {31'd0, if4.tick},     32'((n % 4) == 2));
         check($sformatf("run4_count_e%0d", n), if4.cycle_count,       32'((n + 2) / 4));
         // 3-bit counter: 1..7, 0, 1 over nine rises
         check($sformatf("wrap_count_e%0d", n), {29'd0, if3.cycle_count}, 32'(((n + 1) / 2) % 8));
      end

      // Edge 18 was a DIV=4 rise: drop run in the first high cycle
      if4.run = 1'b0;
      for (int n = 19; n <= 24; n++) begin
         @(negedge clk);
         check($sformatf("halt4_clk_e%0d", n),   {31'd0, if4.proc_clk}, 32'(n == 19));
         check($sformatf("halt4_tick_e%0d", n),  {31'd0, if4.tick},     32'd0);
         check($sformatf("halt4_count_e%0d", n), if4.cycle_count,       32'd5);
      end

      // Single step from HALT: step high on edges 25-27, second edge on 29 ignored
      step_v = 10'b1110100000;
      clk_v  = 10'b0011000000;
      tick_v = 10'b0010000000;
      inc_v  = 10'b0011111111;
      for (int i = 0; i < 10; i++) begin
         if4.step = step_v[i];
         @(negedge clk);
         check($sformatf("step4_clk_e%0d", 25 + i),   {31'd0, if4.proc_clk}, {31'd0, clk_v[i]});
         check($sformatf("step4_tick_e%0d", 25 + i),  {31'd0, if4.tick},     {31'd0, tick_v[i]});
         check($sformatf("step4_count_e%0d", 25 + i), if4.cycle_count,       32'd5 + {31'd0, inc_v[i]});
      end
      if4.step = 1'b0;

      // Asynchronous reset between edges while the DIV=2 clock is high (edge 35)
      @(posedge clk);
      #1;
      check("pre_arst_clk2", {31'd0, if2.proc_clk}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_clk2",   {31'd0, if2.proc_clk}, 32'd0);
      check("arst_tick2",  {31'd0, if2.tick},     32'd0);
      check("arst_count2", if2.cycle_count,       32'd0);
      check("arst_count4", if4.cycle_count,       32'd0);
      check("arst_count3", {29'd0, if3.cycle_count}, 32'd0);

      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
